lcd_scan_ctrl: RTL

LCD_SCAN_CTRL -- requirements
Module: lcd_scan_ctrl

---
 rtl/lcd_scan_pkg.sv | 61 ++++++
 rtl/scan_axis.sv | 56 +++++
 rtl/lcd_scan_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lcd_scan_pkg.sv
// rtl/lcd_scan_pkg.sv - shared types, timing defaults and colour-bar constants for the LCD scan controller
package lcd_scan_pkg;

  localparam int CNT_W = 14;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 32;
  localparam int DEF_PIPE_LAT = 2;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // One slot of the timing delay line; x rides along so the bars line up with de.
  typedef struct packed {
    logic             de;
    logic             hsync_n;
    logic             vsync_n;
    logic             line_start;
    logic             frame_start;
    logic [CNT_W-1:0] x;
  } scan_tap_t;

  localparam scan_tap_t TAP_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                     line_start: 1'b0, frame_start: 1'b0, x: '0};

  // Eight vertical bars, 100 pixels wide each; anything past the last bar is black.
  function automatic logic [15:0] bar_color(input logic [CNT_W-1:0] x);
    logic [CNT_W-1:0] idx;
    idx = x / 14'd100;
    case (idx)
      14'd0:   return BAR_WHITE;
      14'd1:   return BAR_YELLOW;
      14'd2:   return BAR_CYAN;
      14'd3:   return BAR_GREEN;
      14'd4:   return BAR_MAGENTA;
      14'd5:   return BAR_RED;
      14'd6:   return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/scan_axis.sv
// rtl/scan_axis.sv - one timing axis: counter, wrap, phase state machine and active/sync decode
module scan_axis
  import lcd_scan_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             at_zero,
  output logic             active,
  output logic             sync_n
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);

  phase_t           phase;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + 14'd1;
  assign wrap      = advance && (count == LAST);
  assign at_zero   = (count == '0);
  assign active    = (phase == PH_ACTIVE);
  assign sync_n    = (phase != PH_SYNC);

  // Counter and phase advance together so the phase always describes the current count.
  always_ff @(posedge vga_clk) begin
    if (reset || clear) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else if (advance) begin
      if (count == LAST) begin
        count <= '0;
        phase <= PH_ACTIVE;
      end else begin
        count <= count_inc;
        case (phase)
          PH_ACTIVE: if (count_inc == FP_START)   phase <= PH_FP;
          PH_FP:     if (count_inc == SYNC_START) phase <= PH_SYNC;
          PH_SYNC:   if (count_inc == BP_START)   phase <= PH_BP;
          default:   phase <= PH_BP;
        endcase
      end
    end
  end

endmodule

// File: rtl/lcd_scan_ctrl.sv
// rtl/lcd_scan_ctrl.sv - LCD raster scan generator with sync/de delay line and colour-bar source
module lcd_scan_ctrl
  import lcd_scan_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pattern_sel,
  input  logic [4:0]  R_tmp,
  input  logic [5:0]  G_tmp,
  input  logic [4:0]  B_tmp,
  output logic [13:0] xcursor,
  output logic [13:0] ycursor,
  output logic        screen_change,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        frame_start,
  output logic        line_start
);

  logic      h_wrap, h_at_zero, h_active, h_sync_n;
  logic      v_wrap_unused, v_at_zero, v_active, v_sync_n;
  scan_tap_t tap_in;
  scan_tap_t tap_d;
  scan_tap_t pipe [PIPE_LAT];
  logic [15:0] pix_next;

  scan_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .vga_clk (vga_clk),
    .reset   (reset),
    .clear   (!enable),
    .advance (1'b1),
    .count   (xcursor),
    .wrap    (h_wrap),
    .at_zero (h_at_zero),
    .active  (h_active),
    .sync_n  (h_sync_n)
  );

  scan_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .vga_clk (vga_clk),
    .reset   (reset),
    .clear   (!enable),
    .advance (h_wrap),
    .count   (ycursor),
    .wrap    (v_wrap_unused),
    .at_zero (v_at_zero),
    .active  (v_active),
    .sync_n  (v_sync_n)
  );

  // Raw timing for the current cursor; idle values are injected while disabled so the line flushes.
  always_comb begin
    tap_in = TAP_IDLE;
    if (enable) begin
      tap_in.de          = h_active && v_active;
      tap_in.hsync_n     = h_sync_n;
      tap_in.vsync_n     = v_sync_n;
      tap_in.line_start  = h_at_zero && v_active;
      tap_in.frame_start = h_at_zero && v_at_zero;
      tap_in.x           = xcursor;
    end
  end

  // Delay line matching the framebuffer read latency.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= TAP_IDLE;
    end else begin
      pipe[0] <= tap_in;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tap_d = pipe[PIPE_LAT-1];

  // Pixel source select; blanked whenever the delayed de is low.
  always_comb begin
    pix_next = '0;
    if (tap_d.de) pix_next = pattern_sel ? bar_color(tap_d.x) : {R_tmp, G_tmp, B_tmp};
  end

  // Output register: the last stage for timing and the single stage for framebuffer pixels.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      lcd_de        <= 1'b0;
      lcd_hsync     <= 1'b1;
      lcd_vsync     <= 1'b1;
      frame_start   <= 1'b0;
      line_start    <= 1'b0;
      lcd_r         <= '0;
      lcd_g         <= '0;
      lcd_b         <= '0;
      screen_change <= 1'b0;
    end else begin
      lcd_de        <= tap_d.de;
      lcd_hsync     <= tap_d.hsync_n;
      lcd_vsync     <= tap_d.vsync_n;
      frame_start   <= tap_d.frame_start;
      line_start    <= tap_d.line_start;
      lcd_r         <= pix_next[15:11];
      lcd_g         <= pix_next[10:5];
      lcd_b         <= pix_next[4:0];
      screen_change <= enable;
    end
  end

endmodule
